// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with a shared settle/debounce counter.
// Confirmed keys are handed to the consumer over a valid/ready handshake.
module keypad_scanner #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SETTLE     = 4,
    parameter int DEB_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [ROWS-1:0]               row_n,
    input  logic [COLS-1:0]               col_n,
    output logic                          key_valid,
    output logic [$clog2(ROWS*COLS)-1:0]  key_code,
    input  logic                          key_ready,
    output logic                          busy
);

    localparam int KW   = $clog2(ROWS*COLS);
    localparam int RW   = $clog2(ROWS);
    localparam int CIW  = $clog2(COLS);
    localparam int MAXC = (SETTLE > DEB_CYCLES) ? SETTLE : DEB_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        S_SCAN,
        S_CONFIRM,
        S_REPORT,
        S_RELEASE
    } state_e;

    logic [COLS-1:0] col_m_q;
    logic [COLS-1:0] col_s_q;

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CIW-1:0]  cidx_q, cidx_d;
    logic [COLS-1:0] pat_q, pat_d;
    logic [KW-1:0]   code_q, code_d;
    logic            busy_q, busy_d;

    logic [RW-1:0]   row_next;
    logic [CIW-1:0]  first_zero;
    logic            cols_open;
    logic            settle_done;
    logic            deb_done;

    // Two-flop synchronizer for the raw column pins; idle level is all ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_m_q <= '1;
            col_s_q <= '1;
        end else begin
            col_m_q <= col_n;
            col_s_q <= col_m_q;
        end
    end

    // Lowest closed column in the synchronized sample, plus shared helpers
    always_comb begin
        first_zero = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!col_s_q[c]) first_zero = CIW'(c);
        end
        cols_open   = &col_s_q;
        settle_done = (cnt_q == CW'(SETTLE - 1));
        deb_done    = (cnt_q == CW'(DEB_CYCLES - 1));
        row_next    = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
    end

    // State register and all datapath flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_SCAN;
            row_q   <= '0;
            cnt_q   <= '0;
            cidx_q  <= '0;
            pat_q   <= '1;
            code_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            cidx_q  <= cidx_d;
            pat_q   <= pat_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: scan, debounce the press, report, debounce the release
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        cidx_d  = cidx_q;
        pat_d   = pat_q;
        code_d  = code_q;
        busy_d  = busy_q;
        unique case (state_q)
            S_SCAN: begin
                if (!settle_done) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (cols_open) begin
                    row_d = row_next;
                    cnt_d = '0;
                end else begin
                    cidx_d  = first_zero;
                    pat_d   = col_s_q;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_CONFIRM;
                end
            end
            S_CONFIRM: begin
                if (col_s_q != pat_q) begin
                    busy_d  = 1'b0;
                    row_d   = row_next;
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end else if (deb_done) begin
                    code_d  = KW'(int'(row_q) * COLS + int'(cidx_q));
                    cnt_d   = '0;
                    state_d = S_REPORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REPORT: begin
                if (key_ready) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!cols_open) begin
                    cnt_d = '0;
                end else if (deb_done) begin
                    busy_d  = 1'b0;
                    row_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs; rows are released at once while reset is held
    always_comb begin
        key_valid = (state_q == S_REPORT);
        key_code  = code_q;
        busy      = busy_q;
        for (int r = 0; r < ROWS; r++) begin
            row_n[r] = !(rst && (row_q == RW'(r)));
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a switch-matrix model and an expected-code queue.
// Each handshake transfer pops the queue and compares the code.
module tb_keypad_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int KW   = 4;

    logic            clk;
    logic            rst;
    logic [ROWS-1:0] row_n;
    logic [COLS-1:0] col_n;
    logic            key_valid;
    logic [KW-1:0]   key_code;
    logic            key_ready;
    logic            busy;

    logic [ROWS*COLS-1:0] keys;
    int unsigned          sb[$];
    int                   n_cmp;
    int                   n_err;
    int                   n_xfer;

    keypad_scanner #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .SETTLE     (4),
        .DEB_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch matrix: a closed key pulls its column low while its row is driven
    always_comb begin
        col_n = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (keys[r*COLS+c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // sel 0: wait for key_valid; sel 1: wait for busy low
    task automatic wait_for(input string tag, input int sel, input int budget);
        int ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((sel == 0 && key_valid) || (sel == 1 && !busy)) begin
                ok = 1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    // Transfer monitor: every accepted key must match the next expected code
    always @(posedge clk) begin
        if (rst && key_valid && key_ready) begin
            n_xfer++;
            if (sb.size() == 0) check("spurious_event", 1, 0);
            else check("xfer_code", int'(key_code), int'(sb.pop_front()));
        end
    end

    initial begin
        int saw_busy;
        int saw_valid;
        int xf;
        n_cmp     = 0;
        n_err     = 0;
        n_xfer    = 0;
        rst       = 1'b0;
        keys      = '0;
        key_ready = 1'b0;

        tick(2);
        check("rst_row_n", int'(row_n), 4'hF);
        check("rst_valid", int'(key_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_code", int'(key_code), 0);
        rst = 1'b1;
        tick(1);
        check("scan_row0", int'(row_n), 4'hE);

        // Clean press: row 2 / col 1
        key_ready = 1'b1;
        keys[9] = 1'b1;
        sb.push_back(9);
        wait_for("press_valid", 0, 28);
        check("press_busy", int'(busy), 1);
        check("press_code", int'(key_code), 9);
        tick(1);
        check("press_valid_drop", int'(key_valid), 0);
        check("press_one_xfer", n_xfer, 1);
        keys = '0;
        tick(2);
        check("release_busy_hold", int'(busy), 1);
        wait_for("release_idle", 1, 14);
        check("rescan_row0", int'(row_n), 4'hE);

        // Bounce: 5-cycle closure on row 0 / col 3
        saw_busy  = 0;
        saw_valid = 0;
        keys[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            saw_busy  |= int'(busy);
            saw_valid |= int'(key_valid);
        end
        keys = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            saw_valid |= int'(key_valid);
            if (busy) saw_busy = 1;
            else if (saw_busy != 0) break;
        end
        check("bounce_busy_pulse", saw_busy, 1);
        check("bounce_no_valid", saw_valid, 0);
        check("bounce_row1", int'(row_n), 4'hD);
        check("bounce_no_xfer", n_xfer, 1);

        // Backpressure: row 1 / col 2 held off for 50 cycles
        key_ready = 1'b0;
        keys[6] = 1'b1;
        sb.push_back(6);
        wait_for("bp_valid", 0, 40);
        for (int i = 0; i < 50; i++) begin
            if (i == 10) keys = '0;
            @(negedge clk);
            check("bp_valid_hold", int'(key_valid), 1);
            check("bp_code_hold", int'(key_code), 6);
        end
        key_ready = 1'b1;
        tick(1);
        check("bp_valid_drop", int'(key_valid), 0);
        check("bp_one_xfer", n_xfer, 2);
        wait_for("bp_idle", 1, 14);

        // Two columns in row 3: cols 0 and 2, lowest wins
        keys[12] = 1'b1;
        keys[14] = 1'b1;
        sb.push_back(12);
        wait_for("multi_valid", 0, 40);
        check("multi_code", int'(key_code), 12);
        keys = '0;
        wait_for("multi_idle", 1, 14);

        // Release bounce on row 1 / col 1
        keys[5] = 1'b1;
        sb.push_back(5);
        wait_for("rb_valid", 0, 40);
        tick(1);
        xf = n_xfer;
        for (int i = 0; i < 6; i++) begin
            keys[5] = ~keys[5];
            tick(3);
            check("rb_busy", int'(busy), 1);
        end
        keys = '0;
        tick(8);
        check("rb_busy_8", int'(busy), 1);
        wait_for("rb_idle", 1, 4);
        check("rb_one_event", n_xfer, xf);

        // Reset in the middle of REPORT
        key_ready = 1'b0;
        keys[9] = 1'b1;
        wait_for("rst_report_valid", 0, 40);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", int'(key_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_row_n", int'(row_n), 4'hF);
        keys = '0;
        key_ready = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        check("arst_row0", int'(row_n), 4'hE);
        saw_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            saw_valid |= int'(key_valid);
        end
        check("arst_no_stale", saw_valid, 0);
        check("sb_drained", sb.size(), 0);
        check("total_xfers", n_xfer, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Matrix keypad controller. Drives keypad rows one at a time (active-low) and samples the columns.
- Uses one shared debounce timer to confirm a press and then its release.
- Hands each confirmed key to a consumer over a valid/ready handshake.
- Sits between the keypad pins and the command logic that feeds the HD44780 driver.

Parameters:
- ROWS, 4, number of row lines driven (≥2).
- COLS, 4, number of column lines sampled (≥2).
- SETTLE, 4, cycles a row is driven before its columns are sampled (≥3, covers the synchronizer).
- DEB_CYCLES, 1000, consecutive stable cycles needed to confirm a press or a release (≥2).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- row_n  output  ROWS  one-cold row drive; bit r low selects row r.
- col_n  input  COLS  raw column inputs, pulled up; low means a key is closed. Asynchronous to clk.
- key_valid  output  1  key_code holds a confirmed key.
- key_code  output  $clog2(ROWS*COLS)  key index = row*COLS + col.
- key_ready  input  1  consumer accepts key_code.
- busy  output  1  high from press detection until release is confirmed.

Behaviour:
- col_n goes through a 2-flop synchronizer. All decisions use the synchronized value, col_s.
- Reset values (while rst low): row_n all ones, key_valid 0, key_code 0, busy 0, state SCAN, row index 0, all counters 0.
- Reset takes effect immediately in any state, including mid-handshake. A pending key is discarded.
- One counter, width $clog2(max(SETTLE,DEB_CYCLES)+1), serves both settle and debounce timing. It clears on every state or row change.
- SCAN:
  - row_n drives the current row r low.
  - The counter increments each cycle. The sample is taken in the cycle where counter == SETTLE-1.
  - If col_s is all ones: advance r (ROWS-1 wraps to 0), clear the counter, stay in SCAN.
  - Otherwise: latch c = lowest index with col_s[c]==0, latch the pattern col_s, go to CONFIRM. busy goes to 1.
- CONFIRM:
  - Row r is held driven.
  - Each cycle col_s equals the latched pattern, the counter increments.
  - Any mismatch: clear busy, advance r, return to SCAN. No event is produced.
  - When the counter reaches DEB_CYCLES-1 with a match: key_code = r*COLS + c, go to REPORT.
- REPORT:
  - key_valid = 1. key_code is held constant.
  - Transfer happens on a posedge with key_valid && key_ready. key_valid drops the following cycle and the state goes to RELEASE.
  - key_ready may be asserted before key_valid. Transfer then occurs on the first REPORT cycle.
  - Releasing the key during REPORT does not cancel the event.
- RELEASE:
  - Row r is held driven.
  - The counter increments while col_s is all ones. Any low bit clears it.
  - When the counter reaches DEB_CYCLES-1: busy = 0, r = 0, go to SCAN.
- One event per press. Auto-repeat and multi-key rollover are not supported; extra simultaneous keys are ignored.
- Multiple columns low in one row: the lowest column index wins.
- Keys pressed in other rows while busy are not seen until the scan resumes.
- Latency: for a key held stable from an idle scan, key_valid asserts no more than ROWS*SETTLE + DEB_CYCLES + 4 cycles later.
- key_code only changes on entry to REPORT. It holds its last value otherwise.

Test Plan:
Use SETTLE=4, DEB_CYCLES=8, ROWS=COLS=4.
- Clean press: hold row 2 / col 1 closed (model col_n[1] = row_n[2]). Expect key_valid within 28 cycles, key_code=9, busy=1. With key_ready=1, exactly one transfer. After release plus 8 quiet cycles, busy=0 and scan restarts at row 0.
- Bounce rejection: a 5-cycle closure on row 0 / col 3, then open. Expect busy to pulse, no key_valid, and the scan to continue at row 1.
- Backpressure: key_ready=0 for 50 cycles during REPORT. Expect key_valid to stay 1 and key_code constant at the pressed value. Key release in the meantime is ignored. Raise key_ready: exactly one transfer, key_valid=0 the next cycle.
- Simultaneous columns: row 3 with cols 2 and 0 closed. Expect key_code=12.
- Release bounce: after a transfer, toggle the key closed/open at 3-cycle intervals, then open it. Expect no second event, and busy stays 1 until 8 consecutive open cycles.
- Reset mid-operation: assert rst low during REPORT. Expect key_valid=0, busy=0, row_n=4'b1111 asynchronously. After rst goes high, the row 0 drive restarts and no stale event appears.
